unified_mem_arbiter: RTL and testbench

Shares one single-port, word-wide synchronous RAM between ToastCore's instruction-fetch port and data port, so the core can run from a single unified program/data image. Each cycle it grants at most one requester, drives the RAM, and returns read data one cycle later, tagged to the port that issued it. Fixed data-over-fetch priority is bounded by a starvation counter. Per-port stall counters support cycle accounting in the riscv-tests regression.

---
 rtl/unified_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Purpose : shares one single-port word RAM between the fetch port and the data port.
// Latency : grant is combinational in the request cycle; read data returns one cycle later.
// Backpressure: a requester holds its request until granted; data wins unless a fetch has waited MAX_DATA_BURST grants.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  // instruction-fetch port
  input  logic                  I_req,
  input  logic [ADDR_WIDTH-1:0] I_addr,
  input  logic                  I_flush,
  output logic                  I_gnt,
  output logic                  I_rvalid,
  output logic [DATA_WIDTH-1:0] I_rdata,
  // data port
  input  logic                  D_req,
  input  logic                  D_we,
  input  logic [3:0]            D_be,
  input  logic [ADDR_WIDTH-1:0] D_addr,
  input  logic [DATA_WIDTH-1:0] D_wdata,
  output logic                  D_gnt,
  output logic                  D_rvalid,
  output logic [DATA_WIDTH-1:0] D_rdata,
  // RAM side
  output logic                  MEM_en,
  output logic [3:0]            MEM_we,
  output logic [ADDR_WIDTH-3:0] MEM_addr,
  output logic [DATA_WIDTH-1:0] MEM_wdata,
  input  logic [DATA_WIDTH-1:0] MEM_rdata,
  // cycle accounting
  output logic [31:0]           I_stall_count,
  output logic [31:0]           D_stall_count
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_IFETCH = 2'd1,
    TAG_DREAD  = 2'd2
  } tag_e;

  tag_e          tag_q;
  logic [BW-1:0] burst_cnt;
  logic          flush_q;

  // Byte-offset bits never reach the word-addressed RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_addr[1:0], D_addr[1:0]};

  // Grant: data has priority until the waiting fetch has been passed over MAX_DATA_BURST times.
  always_comb begin
    I_gnt = 1'b0;
    D_gnt = 1'b0;
    if (!Reset) begin
      if (D_req && (!I_req || (burst_cnt != BURST_MAX))) begin
        D_gnt = 1'b1;
      end else if (I_req) begin
        I_gnt = 1'b1;
      end
    end
  end

  // RAM drive: steer the winner's address onto the port; only granted data writes touch MEM_we.
  always_comb begin
    MEM_en    = I_gnt | D_gnt;
    MEM_addr  = D_gnt ? D_addr[ADDR_WIDTH-1:2] : I_addr[ADDR_WIDTH-1:2];
    MEM_we    = (D_gnt && D_we) ? D_be : 4'b0000;
    MEM_wdata = D_wdata;
  end

  // Burst counter: counts data grants that pass over a waiting fetch.
  always_ff @(posedge Clk) begin
    if (Reset || !I_req || I_gnt) begin
      burst_cnt <= '0;
    end else if (D_gnt && (burst_cnt != BURST_MAX)) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Response tag and flush flag: remember who owns next cycle's RAM read data.
  // A fetch accepted alongside a flush is the redirect target, so it does not arm the flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tag_q   <= TAG_NONE;
      flush_q <= 1'b0;
    end else begin
      flush_q <= I_flush & ~I_gnt;
      if (I_gnt) begin
        tag_q <= TAG_IFETCH;
      end else if (D_gnt && !D_we) begin
        tag_q <= TAG_DREAD;
      end else begin
        tag_q <= TAG_NONE;
      end
    end
  end

  // Response outputs: data passes straight through, validity comes from the tag.
  always_comb begin
    I_rdata  = MEM_rdata;
    D_rdata  = MEM_rdata;
    I_rvalid = !Reset && (tag_q == TAG_IFETCH) && !flush_q && !I_flush;
    D_rvalid = !Reset && (tag_q == TAG_DREAD);
  end

  // Stall counters: one count per waiting cycle, saturating.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      I_stall_count <= '0;
      D_stall_count <= '0;
    end else begin
      if (I_req && !I_gnt && (I_stall_count != 32'hFFFF_FFFF)) begin
        I_stall_count <= I_stall_count + 32'd1;
      end
      if (D_req && !D_gnt && (D_stall_count != 32'hFFFF_FFFF)) begin
        D_stall_count <= D_stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Purpose : directed checks of arbitration, RAM drive, response tagging, flush and reset.
// Latency : inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
// Backpressure: requests are held until granted, as the handshake requires.
module tb_unified_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        I_req, I_flush, I_gnt, I_rvalid;
  logic [31:0] I_addr, I_rdata;
  logic        D_req, D_we, D_gnt, D_rvalid;
  logic [3:0]  D_be;
  logic [31:0] D_addr, D_wdata, D_rdata;
  logic        MEM_en;
  logic [3:0]  MEM_we;
  logic [29:0] MEM_addr;
  logic [31:0] MEM_wdata, MEM_rdata;
  logic [31:0] I_stall_count, D_stall_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  unified_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_BURST(4)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .I_req(I_req), .I_addr(I_addr), .I_flush(I_flush), .I_gnt(I_gnt),
    .I_rvalid(I_rvalid), .I_rdata(I_rdata),
    .D_req(D_req), .D_we(D_we), .D_be(D_be), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_gnt(D_gnt), .D_rvalid(D_rvalid), .D_rdata(D_rdata),
    .MEM_en(MEM_en), .MEM_we(MEM_we), .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata),
    .MEM_rdata(MEM_rdata),
    .I_stall_count(I_stall_count), .D_stall_count(D_stall_count)
  );

  // Write-first synchronous RAM; the image is (re)loaded while Reset is high.
  logic [31:0] ram [0:4095];
  always @(posedge Clk) begin
    logic [31:0] w;
    if (Reset) begin
      ram[12'h000] <= 32'h0000_0093;
      ram[12'h002] <= 32'h0020_0113;
      ram[12'h004] <= 32'h0D0D_0010;
      ram[12'h010] <= 32'hAAAA_0040;
      ram[12'h020] <= 32'hBBBB_0080;
      ram[12'h801] <= 32'h1122_3344;
    end else if (MEM_en) begin
      w = ram[MEM_addr[11:0]];
      for (int b = 0; b < 4; b++) begin
        if (MEM_we[b]) w[8*b +: 8] = MEM_wdata[8*b +: 8];
      end
      ram[MEM_addr[11:0]] <= w;
      MEM_rdata <= w;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  logic [9:0] exp_i_order;

  initial begin
    exp_i_order = 10'b10_0001_0000;  // fetch wins in slots 4 and 9
    Reset = 1'b1; I_req = 1'b1; I_addr = '0; I_flush = 1'b0;
    D_req = 1'b1; D_we = 1'b0; D_be = 4'h0; D_addr = '0; D_wdata = '0;

    // Reset forces grants off even with both requesting
    @(negedge Clk);
    check("rst_i_gnt", {31'd0, I_gnt}, 32'd0);
    check("rst_d_gnt", {31'd0, D_gnt}, 32'd0);
    check("rst_mem_en", {31'd0, MEM_en}, 32'd0);
    nxt();
    nxt();
    Reset = 1'b0; I_req = 1'b0; D_req = 1'b0;
    @(negedge Clk);
    check("post_rst_i_rvalid", {31'd0, I_rvalid}, 32'd0);
    check("post_rst_d_rvalid", {31'd0, D_rvalid}, 32'd0);
    check("post_rst_i_stall", I_stall_count, 32'd0);
    check("post_rst_d_stall", D_stall_count, 32'd0);
    nxt();

    // Single fetch from word 0
    I_req = 1'b1; I_addr = 32'h0;
    @(negedge Clk);
    check("fetch_i_gnt", {31'd0, I_gnt}, 32'd1);
    check("fetch_d_gnt", {31'd0, D_gnt}, 32'd0);
    check("fetch_mem_en", {31'd0, MEM_en}, 32'd1);
    check("fetch_mem_addr", {2'b00, MEM_addr}, 32'd0);
    check("fetch_mem_we", {28'd0, MEM_we}, 32'd0);
    nxt();
    I_req = 1'b0;
    @(negedge Clk);
    check("fetch_i_rvalid", {31'd0, I_rvalid}, 32'd1);
    check("fetch_i_rdata", I_rdata, 32'h0000_0093);
    check("fetch_d_rvalid", {31'd0, D_rvalid}, 32'd0);
    nxt();

    // Contention: both held high for 10 cycles
    I_req = 1'b1; I_addr = 32'h0; D_req = 1'b1; D_we = 1'b0; D_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check($sformatf("cont_i_gnt[%0d]", i), {31'd0, I_gnt}, {31'd0, exp_i_order[i]});
      check($sformatf("cont_d_gnt[%0d]", i), {31'd0, D_gnt}, {31'd0, ~exp_i_order[i]});
      nxt();
    end
    I_req = 1'b0; D_req = 1'b0;
    @(negedge Clk);
    check("cont_i_stall", I_stall_count, 32'd8);
    check("cont_d_stall", D_stall_count, 32'd2);
    check("cont_last_i_rvalid", {31'd0, I_rvalid}, 32'd1);
    nxt();

    // Partial write then read-back of the same word
    D_req = 1'b1; D_we = 1'b1; D_be = 4'b0011; D_addr = 32'h2004; D_wdata = 32'hDEAD_BEEF;
    @(negedge Clk);
    check("wr_d_gnt", {31'd0, D_gnt}, 32'd1);
    check("wr_mem_we", {28'd0, MEM_we}, 32'h3);
    check("wr_mem_addr", {2'b00, MEM_addr}, 32'h801);
    check("wr_mem_wdata", MEM_wdata, 32'hDEAD_BEEF);
    nxt();
    D_we = 1'b0;
    @(negedge Clk);
    check("rd_d_gnt", {31'd0, D_gnt}, 32'd1);
    check("wr_no_rvalid", {31'd0, D_rvalid}, 32'd0);
    check("rd_mem_we", {28'd0, MEM_we}, 32'd0);
    nxt();
    D_req = 1'b0;
    @(negedge Clk);
    check("rd_d_rvalid", {31'd0, D_rvalid}, 32'd1);
    check("rd_d_rdata", D_rdata, 32'h1122_BEEF);
    check("rd_i_rvalid", {31'd0, I_rvalid}, 32'd0);
    nxt();

    // Flush: drop fetch of 0x40, keep redirect fetch of 0x80
    I_req = 1'b1; I_addr = 32'h40;
    @(negedge Clk);
    check("fl_first_gnt", {31'd0, I_gnt}, 32'd1);
    nxt();
    I_flush = 1'b1; I_addr = 32'h80;
    @(negedge Clk);
    check("fl_redirect_gnt", {31'd0, I_gnt}, 32'd1);
    check("fl_dropped_rvalid", {31'd0, I_rvalid}, 32'd0);
    nxt();
    I_flush = 1'b0; I_req = 1'b0;
    @(negedge Clk);
    check("fl_redirect_rvalid", {31'd0, I_rvalid}, 32'd1);
    check("fl_redirect_rdata", I_rdata, 32'hBBBB_0080);
    nxt();

    // Misaligned fetch address ignores byte offset
    I_req = 1'b1; I_addr = 32'h0000_000B;
    @(negedge Clk);
    check("mis_mem_addr", {2'b00, MEM_addr}, 32'd2);
    nxt();
    I_req = 1'b0;
    @(negedge Clk);
    check("mis_i_rvalid", {31'd0, I_rvalid}, 32'd1);
    check("mis_i_rdata", I_rdata, 32'h0020_0113);
    nxt();

    // Reset while a data read is in flight
    D_req = 1'b1; D_we = 1'b0; D_addr = 32'h10;
    @(negedge Clk);
    check("rr_d_gnt", {31'd0, D_gnt}, 32'd1);
    nxt();
    Reset = 1'b1;
    @(negedge Clk);
    check("rr_in_rst_d_rvalid", {31'd0, D_rvalid}, 32'd0);
    check("rr_in_rst_d_gnt", {31'd0, D_gnt}, 32'd0);
    check("rr_in_rst_mem_en", {31'd0, MEM_en}, 32'd0);
    nxt();
    Reset = 1'b0; D_req = 1'b0;
    @(negedge Clk);
    check("rr_after_d_rvalid", {31'd0, D_rvalid}, 32'd0);
    check("rr_after_i_stall", I_stall_count, 32'd0);
    check("rr_after_d_stall", D_stall_count, 32'd0);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
